// File: rtl/execute_stage_p_pkg.sv
// Shared types for the execute stage: ALU op encoding and control FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package exec_pkg;

    localparam int ALU_OP_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SHL = 3'd5,
        ALU_SHR = 3'd6,
        ALU_MUL = 3'd7
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/execute_stage_p_if.sv
// Op-in / result-out bundle between decode, execute and writeback.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready towards decode, out_valid/out_ready towards writeback.
// Ports: decoded op fields (rdo1, s0, imme, selc_b, aluc, we, rdestr), result fields
//   (s2, rdestrr, wer), handshakes and busy. slave = execute stage, master = its neighbours.
interface execute_stage_p_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int OP_W   = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] rdo1;
    logic [DATA_W-1:0] s0;
    logic [DATA_W-1:0] imme;
    logic              selc_b;
    logic [OP_W-1:0]   aluc;
    logic              we;
    logic [REG_AW-1:0] rdestr;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] s2;
    logic [REG_AW-1:0] rdestrr;
    logic              wer;
    logic              busy;

    modport slave (
        input  in_valid, rdo1, s0, imme, selc_b, aluc, we, rdestr, out_ready,
        output in_ready, out_valid, s2, rdestrr, wer, busy
    );

    modport master (
        output in_valid, rdo1, s0, imme, selc_b, aluc, we, rdestr, out_ready,
        input  in_ready, out_valid, s2, rdestrr, wer, busy
    );
endinterface

// File: rtl/execute_stage_p_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, low DATA_W product bits.
// Latency: DATA_W cycles from start; o_done/o_product are valid during the last step cycle.
// Backpressure: none; the caller only starts it when it can take the result.
// Ports: clk, i_clr (sync clear), i_start/i_a/i_b (operands sampled on start),
//   o_done (last step this cycle), o_product (product as it will be after this step).
module exec_mul_iter #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              i_clr,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_done,
    output logic [DATA_W-1:0] o_product
);
    localparam int          CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic              r_run;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_mcand;   // A, shifted left one place per step
    logic [DATA_W-1:0] r_mplier;  // B, shifted right; bit 0 selects the add
    logic [DATA_W-1:0] w_acc_nxt;

    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_done    = r_run && (r_cnt == LAST);
    // Exposing the next accumulator lets the owner load the result on the last step's edge.
    assign o_product = w_acc_nxt;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_run    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_run    <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
        end else if (r_run) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (r_cnt == LAST) begin
                r_run <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/execute_stage_p.sv
// Execute stage: ALU / immediate bypass in one cycle, iterative multiply in DATA_W steps.
// Latency: 1 cycle for ALU/bypass ops, DATA_W+1 cycles (accept to out_valid) for MUL.
// Backpressure: result held while out_ready=0; in_ready drops while busy, flushing or output stalled.
// Ports: clk, rst (sync, active-high), flush (kills in-flight op and output slot),
//   bus (slave side of execute_stage_p_if: op in, result out, busy).
module execute_stage_p
    import exec_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int OP_W   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    execute_stage_p_if.slave bus
);
    localparam int SH_W = $clog2(DATA_W);

    state_e            r_state;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_s2;
    logic [REG_AW-1:0] r_rdestrr;
    logic              r_wer;
    logic [REG_AW-1:0] r_rd_pend;  // destination parked while the multiply runs
    logic              r_we_pend;

    alu_op_e           w_op;
    logic [DATA_W-1:0] w_alu;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_is_mul;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_mul_prod;

    assign w_op       = alu_op_e'(bus.aluc);
    assign w_in_ready = (r_state == IDLE) && !flush && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    // The immediate bypass overrides the op code, so MUL with selc_b=1 is single-cycle.
    assign w_is_mul   = (w_op == ALU_MUL) && !bus.selc_b;

    always_comb begin
        w_alu = '0;
        case (w_op)
            ALU_ADD: w_alu = bus.rdo1 + bus.s0;
            ALU_SUB: w_alu = bus.rdo1 - bus.s0;
            ALU_AND: w_alu = bus.rdo1 & bus.s0;
            ALU_OR:  w_alu = bus.rdo1 | bus.s0;
            ALU_XOR: w_alu = bus.rdo1 ^ bus.s0;
            ALU_SHL: w_alu = bus.rdo1 << bus.s0[SH_W-1:0];
            ALU_SHR: w_alu = bus.rdo1 >> bus.s0[SH_W-1:0];
            ALU_MUL: w_alu = '0;
            default: w_alu = '0;
        endcase
    end

    exec_mul_iter #(.DATA_W(DATA_W)) u_mul (
        .clk       (clk),
        .i_clr     (rst | flush),
        .i_start   (w_accept && w_is_mul),
        .i_a       (bus.rdo1),
        .i_b       (bus.s0),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_s2        <= '0;
            r_rdestrr   <= '0;
            r_wer       <= 1'b0;
            r_rd_pend   <= '0;
            r_we_pend   <= 1'b0;
        end else if (flush) begin
            // Result fields stay stale; out_valid=0 makes them meaningless downstream.
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
        end else begin
            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state   <= MUL;
                            r_rd_pend <= bus.rdestr;
                            r_we_pend <= bus.we;
                        end else begin
                            r_s2        <= bus.selc_b ? bus.imme : w_alu;
                            r_rdestrr   <= bus.rdestr;
                            r_wer       <= bus.we;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    // Slot is known empty here: acceptance required it empty or draining.
                    if (w_mul_done) begin
                        r_s2        <= w_mul_prod;
                        r_rdestrr   <= r_rd_pend;
                        r_wer       <= r_we_pend;
                        r_out_valid <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.s2        = r_s2;
    assign bus.rdestrr   = r_rdestrr;
    assign bus.wer       = r_wer;
    assign bus.busy      = (r_state == MUL);
endmodule

// File: tb/tb_execute_stage_p.sv
module tb_execute_stage_p;
    logic clk;
    logic rst;
    logic flush;

    execute_stage_p_if #(.DATA_W(16), .REG_AW(4), .OP_W(3)) bus ();

    execute_stage_p #(.DATA_W(16), .REG_AW(4), .OP_W(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] s2;
        logic [3:0]  rd;
        logic        we;
    } exp_t;

    exp_t sb[$];
    int   cons_cyc[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every consumed result is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got s2=0x%0h, none expected (cycle %0d)", bus.s2, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("out_s2",      32'(bus.s2),      32'(mon_e.s2));
                chk("out_rdestrr", 32'(bus.rdestrr), 32'(mon_e.rd));
                chk("out_wer",     32'(bus.wer),     32'(mon_e.we));
                cons_cyc.push_back(cyc);
            end
        end
    end

    // Presents an op and waits (bounded) for acceptance; returns 1 time unit after the accept edge
    // with in_valid still high, so consecutive calls stream back-to-back.
    task automatic send_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm,
                           input logic sel, input logic [2:0] op, input logic [3:0] rd,
                           input logic w, input logic [15:0] exp_s2, input bit push);
        bit ok;
        bus.rdo1     = a;
        bus.s0       = b;
        bus.imme     = imm;
        bus.selc_b   = sel;
        bus.aluc     = op;
        bus.rdestr   = rd;
        bus.we       = w;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1 within 100 cycles");
        end else if (push) begin
            sb.push_back('{s2: exp_s2, rd: rd, we: w});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int base;
        bit saw;
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.rdo1      = '0;
        bus.s0        = '0;
        bus.imme      = '0;
        bus.selc_b    = 1'b0;
        bus.aluc      = '0;
        bus.we        = 1'b0;
        bus.rdestr    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_s2",        32'(bus.s2),        0);
        chk("rst_rdestrr",   32'(bus.rdestrr),   0);
        chk("rst_wer",       32'(bus.wer),       0);
        chk("rst_busy",      32'(bus.busy),      0);
        chk("rst_in_ready",  32'(bus.in_ready),  1);
        @(posedge clk); #1;

        // ADD wraps: 0xFFFF + 2 = 0x0001
        send_op(16'hFFFF, 16'h0002, 16'h0, 1'b0, 3'b000, 4'd3, 1'b1, 16'h0001, 1);
        idle();
        @(negedge clk);
        chk("add_lat1_valid", 32'(bus.out_valid), 1);

        // Immediate bypass with MUL op code: single cycle, never busy
        @(posedge clk); #1;
        send_op(16'h1111, 16'h2222, 16'h1234, 1'b1, 3'b111, 4'd9, 1'b0, 16'h1234, 1);
        idle();
        @(negedge clk);
        chk("imm_busy",  32'(bus.busy),      0);
        chk("imm_valid", 32'(bus.out_valid), 1);

        // MUL 0x0123 * 0x0045 = 0x4E6F; busy for 16 cycles, result in cycle 17
        @(posedge clk); #1;
        send_op(16'h0123, 16'h0045, 16'h0, 1'b0, 3'b111, 4'd7, 1'b1, 16'h4E6F, 1);
        idle();
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k <= 16) begin
                chk($sformatf("mul_busy_c%0d", k),     32'(bus.busy),      1);
                chk($sformatf("mul_in_ready_c%0d", k), 32'(bus.in_ready),  0);
                chk($sformatf("mul_valid_c%0d", k),    32'(bus.out_valid), 0);
            end else begin
                chk("mul_done_valid", 32'(bus.out_valid), 1);
                chk("mul_done_busy",  32'(bus.busy),      0);
            end
        end

        // Stall: SUB 5-7 = 0xFFFE held for 5 cycles, next op accepted on release
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send_op(16'h0005, 16'h0007, 16'h0, 1'b0, 3'b001, 4'd5, 1'b1, 16'hFFFE, 1);
        bus.rdo1 = 16'h0010; bus.s0 = 16'h0020; bus.aluc = 3'b000;
        bus.rdestr = 4'd6; bus.we = 1'b0; bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_valid",    32'(bus.out_valid), 1);
            chk("hold_s2",       32'(bus.s2),        32'h0000FFFE);
            chk("hold_in_ready", 32'(bus.in_ready),  0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 32'(bus.in_ready), 1);
        if (bus.in_ready) sb.push_back('{s2: 16'h0030, rd: 4'd6, we: 1'b0});
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        chk("release_valid", 32'(bus.out_valid), 1);

        // Flush in cycle 8 of a MUL: no result, stale output fields retained
        @(posedge clk); #1;
        send_op(16'hFFFF, 16'hFFFF, 16'h0, 1'b0, 3'b111, 4'd2, 1'b1, 16'h0, 0);
        idle();
        repeat (7) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 32'(bus.in_ready), 0);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy",     32'(bus.busy),      0);
        chk("flush_valid",    32'(bus.out_valid), 0);
        chk("flush_in_ready_after", 32'(bus.in_ready), 1);
        chk("flush_stale_s2", 32'(bus.s2),        32'h00000030);
        saw = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.out_valid) saw = 1'b1;
        end
        chk("flush_no_result", 32'(saw), 0);

        // Flush together with in_valid: op is dropped
        @(posedge clk); #1;
        bus.rdo1 = 16'h0001; bus.s0 = 16'h0001; bus.aluc = 3'b000; bus.selc_b = 1'b0;
        bus.in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("flush_iv_in_ready", 32'(bus.in_ready), 0);
        @(posedge clk); #1;
        flush = 1'b0; idle();
        @(negedge clk);
        chk("flush_iv_valid", 32'(bus.out_valid), 0);

        // Reset mid-MUL: everything back to reset values
        @(posedge clk); #1;
        send_op(16'h0123, 16'h0045, 16'h0, 1'b0, 3'b111, 4'd8, 1'b1, 16'h0, 0);
        idle();
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmul_busy",    32'(bus.busy),      0);
        chk("rstmul_valid",   32'(bus.out_valid), 0);
        chk("rstmul_s2",      32'(bus.s2),        0);
        chk("rstmul_rdestrr", 32'(bus.rdestrr),   0);
        chk("rstmul_wer",     32'(bus.wer),       0);
        saw = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.out_valid) saw = 1'b1;
        end
        chk("rstmul_no_result", 32'(saw), 0);

        // Recovery: AND, and MUL wrap 0xFFFF*0xFFFF -> 0x0001
        @(posedge clk); #1;
        send_op(16'hFF0F, 16'h0FF0, 16'h0, 1'b0, 3'b010, 4'd1, 1'b1, 16'h0F00, 1);
        send_op(16'hFFFF, 16'hFFFF, 16'h0, 1'b0, 3'b111, 4'd4, 1'b1, 16'h0001, 1);
        idle();
        repeat (20) @(posedge clk);
        #1;

        // Stream: XOR, SHL (amount 0x14 truncates to 4), SHR by 15, OR
        base = cons_cyc.size();
        send_op(16'hF0F0, 16'h0FF0, 16'h0, 1'b0, 3'b100, 4'd10, 1'b1, 16'hFF00, 1);
        send_op(16'h1234, 16'h0014, 16'h0, 1'b0, 3'b101, 4'd11, 1'b0, 16'h2340, 1);
        send_op(16'h8000, 16'h000F, 16'h0, 1'b0, 3'b110, 4'd12, 1'b1, 16'h0001, 1);
        send_op(16'h00F0, 16'h0F00, 16'h0, 1'b0, 3'b011, 4'd13, 1'b1, 16'h0FF0, 1);
        idle();

        for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 32'(sb.size()), 0);
        chk("stream_count", 32'(cons_cyc.size() - base), 4);
        if (cons_cyc.size() >= base + 4) begin
            for (int k = 0; k < 3; k++)
                chk($sformatf("stream_gap_%0d", k),
                    32'(cons_cyc[base + k + 1] - cons_cyc[base + k]), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
